// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared fetch-sequencer state encoding and reset constants
package cpu_defs;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register and req/ack instruction fetch sequencer
module pc_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault,
  output logic [31:0] instr_count
);

  fetch_state_t state, state_next;
  logic         capture;
  logic         accept;
  logic         load_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_count <= 32'h0;
    end else begin
      state <= state_next;
      if (capture) instr <= imem_rdata;
      if (accept) instr_count <= instr_count + 32'd1;
      if (load_pc) pc <= next_pc;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    accept     = 1'b0;
    load_pc    = 1'b0;
    case (state)
      ST_BOOT: state_next = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          accept = 1'b1;
          // A misaligned target is never loaded; pc keeps the last good value.
          if (word_aligned(next_pc)) begin
            load_pc    = 1'b1;
            state_next = ST_REQ;
          end else begin
            state_next = ST_FAULT;
          end
        end
      end
      default: state_next = ST_FAULT;
    endcase
  end

  assign imem_req    = (state == ST_REQ);
  assign instr_valid = (state == ST_HOLD);
  assign fetch_fault = (state == ST_FAULT);
  assign imem_addr   = pc;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - randomized and directed checks of pc_fetch against a transaction model
module tb_pc_fetch;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] next_pc = 32'h0;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fetch_fault;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Model: what the fetch unit is doing, tracked as plain flags.
  logic [31:0] m_pc, m_instr, m_count;
  logic        m_booting, m_fetching, m_holding, m_faulted;

  pc_fetch #(.RESET_PC(RESET_PC_DEFAULT)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_fault(fetch_fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("imem_req", {31'b0, imem_req}, {31'b0, m_fetching});
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_holding});
    check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_faulted});
    check("instr_count", instr_count, m_count);
    check("instr", instr, m_instr);
  endtask

  // Check current outputs, drive one cycle of inputs, advance the model.
  task automatic step(input logic r, input logic a, input logic [31:0] rd,
                      input logic rdy, input logic [31:0] npc);
    @(negedge clk);
    compare_model();
    rst = r; imem_ack = a; imem_rdata = rd; instr_ready = rdy; next_pc = npc;
    if (r) begin
      m_pc = RESET_PC_DEFAULT; m_instr = 0; m_count = 0;
      m_booting = 1; m_fetching = 0; m_holding = 0; m_faulted = 0;
    end else if (m_booting) begin
      m_booting = 0; m_fetching = 1;
    end else if (m_fetching && a) begin
      m_instr = rd; m_fetching = 0; m_holding = 1;
    end else if (m_holding && rdy) begin
      m_holding = 0;
      m_count = m_count + 1;
      if (npc % 4 == 0) begin
        m_pc = npc; m_fetching = 1;
      end else begin
        m_faulted = 1;
      end
    end
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_pc = RESET_PC_DEFAULT; m_instr = 0; m_count = 0;
    m_booting = 1; m_fetching = 0; m_holding = 0; m_faulted = 0;

    // Reset, then zero-wait memory with decode always ready.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h2000_0000 + i, 1, 0);
      step(0, 0, 0, 1, m_pc + 4);
    end
    post_edge();
    check("seq_pc", pc, 32'h0000_300C);
    check("seq_count", instr_count, 32'd3);

    // Three wait cycles before ack.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    post_edge();
    check("wait_req", {31'b0, imem_req}, 32'd1);
    check("wait_addr", imem_addr, 32'h0000_300C);
    step(0, 1, 32'h1000_0003, 0, 0);
    post_edge();
    check("wait_instr", instr, 32'h1000_0003);
    check("wait_valid", {31'b0, instr_valid}, 32'd1);

    // Decode stall with spurious ack, then accept to 3040.
    for (int i = 0; i < 5; i++) step(0, 1, 32'hDEAD_BEEF, 0, 32'h0000_3002);
    step(0, 0, 0, 1, 32'h0000_3040);
    post_edge();
    check("stall_pc", pc, 32'h0000_3040);
    check("stall_instr", instr, 32'h1000_0003);

    // Spurious ready during REQ, then misaligned target.
    step(0, 0, 0, 1, 32'h0000_3100);
    step(0, 1, 32'h0BAD_0001, 1, 32'h0000_3100);
    step(0, 0, 0, 1, 32'h0000_3002);
    post_edge();
    check("fault_flag", {31'b0, fetch_fault}, 32'd1);
    check("fault_pc", pc, 32'h0000_3040);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h1234_5678, 1, 32'h0000_3200);

    // Reset while ack arrives in REQ.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'hFFFF_0000, 1, 32'h0000_3300);
    post_edge();
    check("rst_pc", pc, RESET_PC_DEFAULT);
    check("rst_instr", instr, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r, a, rdy;
      logic [31:0] npc;
      r   = ($urandom_range(0, 63) == 0);
      a   = $urandom_range(0, 1) == 1;
      rdy = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 15))
        0:       npc = {$urandom} | 32'h1;
        1, 2:    npc = {$urandom} & 32'hFFFF_FFFC;
        default: npc = m_pc + 4;
      endcase
      step(r, a, $urandom, rdy, npc);
    end
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
